// File: rtl/mod4051_pkg.sv
// Shared definitions for the mod-4051 datapath blocks: modulus, residue width,
// sequencer state encoding and the 13-bit conditional-subtract reduction.
package mod4051_pkg;

    localparam logic [11:0] MOD_P = 12'd4051;
    localparam int          RW    = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        ACCUM  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Reduces a sum of two residues (at most 2*(MOD_P-1)) back into 0..MOD_P-1.
    function automatic logic [11:0] csub13(input logic [12:0] s);
        logic [12:0] p13;
        logic [12:0] d;
        p13 = {1'b0, MOD_P};
        d   = s - p13;
        return (s >= p13) ? d[11:0] : s[11:0];
    endfunction

endpackage

// File: rtl/mod4051_x500_lut.sv
// Combinational x500 partial-product tables, 64 entries each:
// t_hi = (idx_hi*64*500) mod 4051, t_lo = (idx_lo*500) mod 4051.
module mod4051_x500_lut
    import mod4051_pkg::*;
(
    input  logic [5:0]    idx_hi,
    input  logic [5:0]    idx_lo,
    output logic [RW-1:0] t_hi,
    output logic [RW-1:0] t_lo
);

    logic [RW-1:0] hi_tab [64];
    logic [RW-1:0] lo_tab [64];

    // Table contents are elaboration-time constants, so each output bit maps to a 6-input LUT.
    for (genvar gi = 0; gi < 64; gi++) begin : g_tab
        localparam int HI_VAL = (gi * 64 * 500) % int'(MOD_P);
        localparam int LO_VAL = (gi * 500) % int'(MOD_P);
        assign hi_tab[gi] = RW'(HI_VAL);
        assign lo_tab[gi] = RW'(LO_VAL);
    end

    assign t_hi = hi_tab[idx_hi];
    assign t_lo = lo_tab[idx_lo];

endmodule

// File: rtl/mod4051_x500_seq.sv
// Iterative a * 500^k mod 4051 sequencer, two cycles per iteration.
// Optional operand range check compiled in with MOD4051_SEQ_RANGE_CHECK_EN.
module mod4051_x500_seq
    import mod4051_pkg::*;
#(
    parameter int KW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [RW-1:0] in_a,
    input  logic [KW-1:0] in_k,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_res,
    output logic          out_err
);

    state_t        state, state_next;
    logic [RW-1:0] acc, acc_next;
    logic [KW-1:0] cnt, cnt_next;
    logic [RW-1:0] phi, plo;
    logic          err, err_next;
    logic [RW-1:0] t_hi, t_lo;

    mod4051_x500_lut u_lut (
        .idx_hi (acc[11:6]),
        .idx_lo (acc[5:0]),
        .t_hi   (t_hi),
        .t_lo   (t_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            phi   <= '0;
            plo   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
            err   <= err_next;
            if (state == LOOKUP) begin
                phi <= t_hi;
                plo <= t_lo;
            end
        end
    end

    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        err_next   = err;
        case (state)
            IDLE: begin
                err_next = 1'b0;
                if (in_valid) begin
                    acc_next = in_a;
                    cnt_next = in_k;
`ifdef MOD4051_SEQ_RANGE_CHECK_EN
                    if (in_a >= MOD_P) begin
                        acc_next   = '0;
                        err_next   = 1'b1;
                        state_next = DONE;
                    end else
`endif
                    if (in_k == '0) state_next = DONE;
                    else            state_next = LOOKUP;
                end
            end
            LOOKUP: state_next = ACCUM;
            ACCUM: begin
                acc_next   = csub13({1'b0, phi} + {1'b0, plo});
                cnt_next   = cnt - KW'(1);
                state_next = (cnt == KW'(1)) ? DONE : LOOKUP;
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                    err_next   = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs depend only on registered state, never on the current inputs.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_res   = (state == DONE) ? acc : '0;
    assign out_err   = err;

endmodule

// File: tb/tb_mod4051_x500_seq.sv
// Directed self-checking bench for mod4051_x500_seq; expected results hand-computed.
// Define MOD4051_SEQ_RANGE_CHECK_EN to exercise the range-check build.
module tb_mod4051_x500_seq;

    localparam int KW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [11:0]   in_a = '0;
    logic [KW-1:0] in_k = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [11:0]   out_res;
    logic          out_err;

    int n_tests = 0;
    int n_fail  = 0;

    mod4051_x500_seq #(.KW(KW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_k      (in_k),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
        end
    endtask

    // Issue one request, measure latency in samples after the accept edge,
    // optionally stall the result for 'hold' cycles, then complete the handshake.
    task automatic do_req(input logic [11:0] a, input logic [KW-1:0] k,
                          input int exp_res, input int exp_lat, input int exp_err,
                          input int hold);
        int  lat;
        bit  seen;
        @(negedge clk);
        check("in_ready_before", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_k     = k;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat  = 0;
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            lat++;
            if (out_valid) seen = 1;
        end
        if (!seen) begin
            check("timeout", 32'd0, 32'd1);
        end else begin
            check("latency", 32'(lat), 32'(exp_lat));
            check("out_res", 32'(out_res), 32'(exp_res));
            check("out_err", 32'(out_err), 32'(exp_err));
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_res", 32'(out_res), 32'(exp_res));
                check("hold_in_ready", 32'(in_ready), 32'd0);
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check("in_ready_after", 32'(in_ready), 32'd1);
            check("valid_after", 32'(out_valid), 32'd0);
        end
        $display("[TB] req a=%0d k=%0d -> res=%0d err=%0d lat=%0d", a, k, exp_res, exp_err, lat);
    endtask

    initial begin
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_res", 32'(out_res), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_req(12'd1,    4'd1, 500,  3, 0, 0);
        do_req(12'd1,    4'd2, 2889, 5, 0, 0);
        do_req(12'd4050, 4'd1, 3551, 3, 0, 0);
        do_req(12'd77,   4'd0, 77,   1, 0, 0);
        do_req(12'd2,    4'd1, 1000, 3, 0, 0);
        do_req(12'd1,    4'd3, 2344, 7, 0, 0);
        do_req(12'd4032, 4'd1, 2653, 3, 0, 0);
        do_req(12'd4050, 4'd2, 1162, 5, 0, 0);
        do_req(12'd0,    4'd15, 0,  31, 0, 0);
        do_req(12'd1,    4'd1, 500,  3, 0, 10);

        // Asynchronous reset in the middle of an iteration.
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 12'd1;
        in_k     = 4'd5;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_res", 32'(out_res), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        $display("[TB] reset asserted mid-run (a=1 k=5)");
        @(negedge clk);
        rst_n = 1'b1;
        do_req(12'd1, 4'd1, 500, 3, 0, 0);

`ifdef MOD4051_SEQ_RANGE_CHECK_EN
        do_req(12'd4051, 4'd3, 0, 1, 1, 0);
        check("err_cleared", 32'(out_err), 32'd0);
`else
        do_req(12'd4051, 4'd3, 0, 7, 0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
